decode_rf_sb: RTL and testbench
===============================

DECODE_RF_SB -- requirements
Module: decode_rf_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width (≥16).
REQ-002 SHALL have parameter REG_NUM, default 32, register count (power of 2); AW = log2(REG_NUM), LINK = REG_NUM-1.
REQ-003 clock  in  1  rising-edge clock; the block uses one clock.
REQ-004 reset  in  1  reset, asynchronous, active-low.
REQ-005 instr  in  32  decode-stage instruction: opcode [31:26], rs [25:21], rt [20:16], imm [15:0].
REQ-006 rd_data_1 / rd_data_2  out  DATA_W each  register contents at rs / rt (low AW bits of each field).
REQ-007 imm_ext  out  DATA_W  extended immediate.
REQ-008 issue_valid  in  1  decode instruction presented; issue_load  in  1  it is a load writing rt.
REQ-009 stall  out  1  decode instruction must hold this cycle.
REQ-010 wb_valid, reg_write, mem_to_reg, reg_dst, jal  in  1 each  write-back stage controls.
REQ-011 wb_rt, wb_rd  in  AW each  write-back candidate destinations.
REQ-012 alu_result, mem_data, link_addr  in  DATA_W each  write-back sources (link_addr = PC+4).
REQ-013 pend_cnt  out  AW+1  number of registers with a pending load.

Function
REQ-014 imm_ext SHALL be zero-extended for opcodes 0x0B, 0x0C, 0x0D, 0x0E and sign-extended from imm[15] otherwise; combinational.
REQ-015 Write destination SHALL be LINK if jal, else wb_rd if reg_dst, else wb_rt; defined for every input combination (no latch).
REQ-016 Write data SHALL be link_addr if jal, else mem_data if mem_to_reg, else alu_result (jal takes priority).
REQ-017 Write enable we = wb_valid & reg_write & (dest != 0); the register SHALL update on the rising clock edge when we=1.
REQ-018 Reads SHALL be combinational; register 0 SHALL always read 0 and never be written.
REQ-019 Scoreboard: one pending bit per register; bit 0 permanently 0.
REQ-020 Accept = issue_valid & issue_load & !stall & (rt != 0) SHALL set pending[rt] at the next edge.
REQ-021 A write with we=1 SHALL clear pending[dest] at the next edge.
REQ-022 On simultaneous set and clear of the same register, set SHALL win.
REQ-023 stall = issue_valid & (pending[rs] | pending[rt]); combinational, using current pending bits (a clear in the same cycle does not release the stall until the next cycle unless bypass is enabled).
REQ-024 pend_cnt SHALL equal the population count of the pending bits, registered and updated in the same edge as the bits; it cannot exceed REG_NUM-1.

Reset
REQ-025 reset low SHALL asynchronously clear all registers, all pending bits and pend_cnt to 0; all outputs then read 0 (imm_ext follows instr).
REQ-026 Deassertion SHALL be taken synchronously; the first write is accepted on the first edge after release.
REQ-027 Reset mid-load SHALL discard pending state; a late write-back after release is an ordinary write.

Configuration
REQ-028 Macro DECODE_RF_BYPASS_EN SHALL, when defined, forward write data to a read port whose address equals dest while we=1, and exclude a pending bit from stall when that register's clear occurs in the same cycle.
REQ-029 Without DECODE_RF_BYPASS_EN, reads SHALL return stored contents, and stall SHALL persist for one further cycle after the clearing write.

Structure
REQ-030 Opcode constants (OP_JAL=0x03, OP_SLTIU=0x0B, OP_ANDI=0x0C, OP_ORI=0x0D, OP_XORI=0x0E) SHALL live in shared package cpu_pkg.
REQ-031 Scoreboard (pending bits, pend_cnt, stall term) SHALL be sub-module reg_scoreboard; storage and muxes stay in the top level.

Verification
REQ-032 Reset, write alu_result=0x12345678 to r5 (reg_dst=1, wb_rd=5), then read rs=5 -> rd_data_1=0x12345678.
REQ-033 Write-back to r0 with data 0xFFFFFFFF -> rs=0 reads 0.
REQ-034 jal=1, link_addr=0x00400008, mem_to_reg=1 -> r31=0x00400008.
REQ-035 instr imm=0x8000: opcode 0x0D -> imm_ext=0x00008000; opcode 0x08 -> 0xFFFF8000.
REQ-036 Accept load to r7, next instruction rs=7 -> stall=1, pend_cnt=1; write r7 -> stall falls the same cycle with bypass, one cycle later without; pend_cnt=0.
REQ-037 Accept load to r9 and write r9 in the same cycle -> pending[9]=1, pend_cnt=1; assert reset mid-stall -> stall=0, pend_cnt=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU decode constants and small helpers.
package cpu_pkg;

    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    // Logical and unsigned-compare immediates take a zero-extended operand.
    function automatic logic is_zext_op(input logic [5:0] op);
        return (op == OP_SLTIU) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one bit per register, population count and decode stall.
// Macro DECODE_RF_BYPASS_EN lets a same-cycle clearing write release the stall.
module reg_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int AW      = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic          issue_load,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    output logic          stall,
    output logic [AW:0]   pend_cnt
);

    logic [REG_NUM-1:0] pending;
    logic [REG_NUM-1:0] pending_nxt;
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] clr_mask;
    logic [REG_NUM-1:0] pend_eff;
    logic [AW:0]        cnt_nxt;
    logic               accept;

    always_comb begin
        clr_mask = '0;
        if (clr_en) begin
            clr_mask[clr_addr] = 1'b1;
        end
`ifdef DECODE_RF_BYPASS_EN
        pend_eff = pending & ~clr_mask;
`else
        pend_eff = pending;
`endif
        stall  = issue_valid & (pend_eff[rs] | pend_eff[rt]);
        accept = issue_valid & issue_load & ~stall & (rt != '0);

        set_mask = '0;
        if (accept) begin
            set_mask[rt] = 1'b1;
        end
        // Set is applied after clear so a same-register collision stays pending.
        pending_nxt    = (pending & ~clr_mask) | set_mask;
        pending_nxt[0] = 1'b0;

        cnt_nxt = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(pending_nxt[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/decode_rf_sb.sv
// Decode-stage register file with write-back muxing, immediate extension and load scoreboard.
// Macro DECODE_RF_BYPASS_EN forwards write-back data to matching read ports.
module decode_rf_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    localparam int AW     = $clog2(REG_NUM)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic [DATA_W-1:0] imm_ext,
    input  logic              issue_valid,
    input  logic              issue_load,
    output logic              stall,
    input  logic              wb_valid,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              reg_dst,
    input  logic              jal,
    input  logic [AW-1:0]     wb_rt,
    input  logic [AW-1:0]     wb_rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] link_addr,
    output logic [AW:0]       pend_cnt
);

    localparam logic [AW-1:0] LINK = AW'(REG_NUM - 1);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] wb_data;
    logic              we;

    assign rs = instr[21 +: AW];
    assign rt = instr[16 +: AW];

    always_comb begin
        dest    = wb_rt;
        wb_data = alu_result;
        if (jal) begin
            dest    = LINK;
            wb_data = link_addr;
        end else begin
            if (reg_dst) begin
                dest = wb_rd;
            end
            if (mem_to_reg) begin
                wb_data = mem_data;
            end
        end
        we = wb_valid & reg_write & (dest != '0);
    end

    always_comb begin
        if (is_zext_op(instr[31:26])) begin
            imm_ext = DATA_W'(instr[15:0]);
        end else begin
            imm_ext = DATA_W'($signed(instr[15:0]));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[dest] <= wb_data;
        end
    end

    // Register 0 is hardwired; we never targets it, so bypass needs no zero check.
    always_comb begin
        rd_data_1 = (rs == '0) ? '0 : regs[rs];
        rd_data_2 = (rt == '0) ? '0 : regs[rt];
`ifdef DECODE_RF_BYPASS_EN
        if (we && (dest == rs)) begin
            rd_data_1 = wb_data;
        end
        if (we && (dest == rt)) begin
            rd_data_2 = wb_data;
        end
`endif
    end

    reg_scoreboard #(
        .REG_NUM (REG_NUM),
        .AW      (AW)
    ) u_sb (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_load  (issue_load),
        .rs          (rs),
        .rt          (rt),
        .clr_en      (we),
        .clr_addr    (dest),
        .stall       (stall),
        .pend_cnt    (pend_cnt)
    );

endmodule

// File: tb/tb_decode_rf_sb.sv
// Self-checking bench for decode_rf_sb: directed scenarios plus randomized traffic vs a reference model.
module tb_decode_rf_sb;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] rd_data_1, rd_data_2, imm_ext;
    logic        issue_valid, issue_load, stall;
    logic        wb_valid, reg_write, mem_to_reg, reg_dst, jal;
    logic [4:0]  wb_rt, wb_rd;
    logic [31:0] alu_result, mem_data, link_addr;
    logic [5:0]  pend_cnt;

    int n_checks = 0;
    int n_errors = 0;

    bit [31:0] m_reg  [32];
    bit        m_pend [32];

    always #5 clock = ~clock;

    decode_rf_sb dut (
        .clock(clock), .reset(reset), .instr(instr),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2), .imm_ext(imm_ext),
        .issue_valid(issue_valid), .issue_load(issue_load), .stall(stall),
        .wb_valid(wb_valid), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .jal(jal), .wb_rt(wb_rt), .wb_rd(wb_rd),
        .alu_result(alu_result), .mem_data(mem_data), .link_addr(link_addr),
        .pend_cnt(pend_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_dest();
        if (jal) return 31;
        return reg_dst ? int'(wb_rd) : int'(wb_rt);
    endfunction

    function automatic bit [31:0] m_data();
        if (jal) return link_addr;
        return mem_to_reg ? mem_data : alu_result;
    endfunction

    function automatic bit m_we();
        return wb_valid && reg_write && (m_dest() != 0);
    endfunction

    function automatic bit m_busy(input int r);
        bit b = m_pend[r];
`ifdef DECODE_RF_BYPASS_EN
        if (m_we() && m_dest() == r) b = 0;
`endif
        return b;
    endfunction

    function automatic bit [31:0] m_read(input int r);
        bit [31:0] v = (r == 0) ? 32'h0 : m_reg[r];
`ifdef DECODE_RF_BYPASS_EN
        if (m_we() && m_dest() == r) v = m_data();
`endif
        return v;
    endfunction

    function automatic bit m_stall();
        return issue_valid && (m_busy(int'(instr[25:21])) || m_busy(int'(instr[20:16])));
    endfunction

    function automatic bit [31:0] m_imm();
        int op = int'(instr[31:26]);
        if (op >= 'h0B && op <= 'h0E) return {16'h0, instr[15:0]};
        return {{16{instr[15]}}, instr[15:0]};
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_pend[i];
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 0;
        end
    endtask

    task automatic settle_and_check();
        #1;
        check("rd_data_1", rd_data_1, m_read(int'(instr[25:21])));
        check("rd_data_2", rd_data_2, m_read(int'(instr[20:16])));
        check("imm_ext",   imm_ext,   m_imm());
        check("stall",     32'(stall), 32'(m_stall()));
        check("pend_cnt",  32'(pend_cnt), 32'(m_count()));
    endtask

    task automatic advance();
        int  rt = int'(instr[20:16]);
        bit  acc = issue_valid && issue_load && !m_stall() && rt != 0;
        if (m_we()) begin
            m_reg[m_dest()]  = m_data();
            m_pend[m_dest()] = 0;
        end
        if (acc) m_pend[rt] = 1;
        @(negedge clock);
    endtask

    task automatic idle();
        issue_valid = 0; issue_load = 0;
        wb_valid = 0; reg_write = 0; mem_to_reg = 0; reg_dst = 0; jal = 0;
        wb_rt = 0; wb_rd = 0; alu_result = 0; mem_data = 0; link_addr = 0;
    endtask

    function automatic logic [31:0] mk_instr(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic int pick_reg();
        int r = $urandom_range(0, 9);
        if (r == 8) return 31;
        if (r == 9) return $urandom_range(0, 31);
        return r;
    endfunction

    task automatic randomize_inputs();
        int ops [8] = '{'h0B, 'h0C, 'h0D, 'h0E, 'h0A, 'h0F, 'h08, 'h23};
        int op = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : ops[$urandom_range(0, 7)];
        instr       = mk_instr(op, pick_reg(), pick_reg(), $urandom_range(0, 65535));
        issue_valid = $urandom_range(0, 3) != 0;
        issue_load  = $urandom_range(0, 1);
        wb_valid    = $urandom_range(0, 2) != 0;
        reg_write   = $urandom_range(0, 3) != 0;
        mem_to_reg  = $urandom_range(0, 1);
        reg_dst     = $urandom_range(0, 1);
        jal         = $urandom_range(0, 7) == 0;
        wb_rt       = 5'(pick_reg());
        wb_rd       = 5'(pick_reg());
        alu_result  = $urandom();
        mem_data    = $urandom();
        link_addr   = $urandom();
    endtask

    initial begin
        reset = 0;
        idle();
        instr = 32'h0;
        model_clear();
        #2;
        check("reset_rd1", rd_data_1, 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_cnt", 32'(pend_cnt), 32'h0);
        @(negedge clock);
        reset = 1;

        // Write 0x12345678 to r5 via rd, then read it back.
        wb_valid = 1; reg_write = 1; reg_dst = 1; wb_rd = 5; alu_result = 32'h12345678;
        settle_and_check(); advance();
        idle(); instr = mk_instr('h08, 5, 0, 0);
        settle_and_check();
        check("r5_read", rd_data_1, 32'h12345678);
        advance();

        // Write-back targeting r0 must be discarded.
        wb_valid = 1; reg_write = 1; wb_rt = 0; alu_result = 32'hFFFFFFFF;
        settle_and_check(); advance();
        idle(); instr = mk_instr('h08, 0, 0, 0);
        settle_and_check();
        check("r0_read", rd_data_1, 32'h0);
        advance();

        // jal overrides mem_to_reg and writes the link register.
        wb_valid = 1; reg_write = 1; jal = 1; mem_to_reg = 1;
        link_addr = 32'h00400008; mem_data = 32'hDEADBEEF;
        settle_and_check(); advance();
        idle(); instr = mk_instr('h08, 31, 0, 0);
        settle_and_check();
        check("r31_link", rd_data_1, 32'h00400008);
        advance();

        instr = mk_instr('h0D, 0, 0, 'h8000);
        settle_and_check();
        check("imm_ori", imm_ext, 32'h00008000);
        instr = mk_instr('h08, 0, 0, 'h8000);
        settle_and_check();
        check("imm_addi", imm_ext, 32'hFFFF8000);
        advance();

        // Load to r7, dependent instruction stalls until r7 is written.
        instr = mk_instr('h23, 0, 7, 0); issue_valid = 1; issue_load = 1;
        settle_and_check(); advance();
        issue_load = 0; instr = mk_instr('h08, 7, 0, 0);
        settle_and_check();
        check("r7_stall", 32'(stall), 32'h1);
        check("r7_cnt", 32'(pend_cnt), 32'h1);
        advance();
        wb_valid = 1; reg_write = 1; mem_to_reg = 1; wb_rt = 7; mem_data = 32'hCAFE0007;
        settle_and_check();
`ifdef DECODE_RF_BYPASS_EN
        check("r7_stall_clr", 32'(stall), 32'h0);
`else
        check("r7_stall_clr", 32'(stall), 32'h1);
`endif
        advance();
        wb_valid = 0; reg_write = 0;
        settle_and_check();
        check("r7_stall_after", 32'(stall), 32'h0);
        check("r7_cnt_after", 32'(pend_cnt), 32'h0);
        check("r7_data", rd_data_1, 32'hCAFE0007);
        advance();

        // Simultaneous set and clear of r9: set wins. Then reset mid-stall.
        instr = mk_instr('h23, 0, 9, 0); issue_valid = 1; issue_load = 1;
        wb_valid = 1; reg_write = 1; wb_rt = 9; alu_result = 32'h99;
        settle_and_check(); advance();
        idle(); issue_valid = 1; instr = mk_instr('h08, 9, 0, 0);
        settle_and_check();
        check("r9_cnt", 32'(pend_cnt), 32'h1);
        check("r9_stall", 32'(stall), 32'h1);
        reset = 0;
        model_clear();
        settle_and_check();
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_cnt", 32'(pend_cnt), 32'h0);
        @(negedge clock);
        reset = 1;
        idle();
        wb_valid = 1; reg_write = 1; wb_rt = 9; alu_result = 32'h55AA;
        settle_and_check(); advance();
        idle(); instr = mk_instr('h08, 9, 0, 0);
        settle_and_check();
        check("late_wb", rd_data_1, 32'h55AA);
        advance();

        for (int n = 0; n < 600; n++) begin
            randomize_inputs();
            settle_and_check();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
